// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibits the bus, issues a start bit,
// shifts data/parity/stop on device clock falling edges and reports ack/nack/timeout.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES       = 12000,
  parameter int unsigned START_TIMEOUT_CYCLES = 1500000,
  parameter int unsigned XFER_TIMEOUT_CYCLES  = 200000
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic [1:0] status,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic [2:0] dbg_state_o
);

  // Handshake: a byte is taken on a clock edge where tx_valid && tx_ready;
  // tx_ready is high only in IDLE, and requests while busy are dropped, not queued.

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND_WAIT, S_SEND, S_ACK, S_WAIT_IDLE, S_FINISH
  } state_t;

  localparam logic [31:0] INH_LAST   = 32'(INHIBIT_CYCLES - 1);
  localparam logic [31:0] START_LAST = 32'(START_TIMEOUT_CYCLES - 1);
  localparam logic [31:0] XFER_LAST  = 32'(XFER_TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [9:0]  frame_q, frame_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  status_q, status_d;
  logic        data_oe_q, data_oe_d;

  // Idle lines float high, so the synchronisers reset to 1 to avoid a false edge.
  logic clk_s1_q, clk_s2_q, clk_prev_q, data_s1_q, data_s2_q;
  logic clk_fall;

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data_in;
      data_s2_q  <= data_s1_q;
    end
  end

  assign clk_fall = clk_prev_q & ~clk_s2_q;

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      status_q  <= 2'b00;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      status_q  <= status_d;
      data_oe_q <= data_oe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    status_d  = status_q;
    data_oe_d = data_oe_q;
    case (state_q)
      S_IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid) begin
          frame_d = {1'b1, ~^tx_data, tx_data};
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = S_REQ;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_REQ: begin
        cnt_d   = '0;
        state_d = S_SEND_WAIT;
      end
      S_SEND_WAIT: begin
        if (cnt_q == START_LAST) begin
          data_oe_d = 1'b0;
          status_d  = 2'b10;
          state_d   = S_FINISH;
        end else if (clk_fall) begin
          data_oe_d = ~frame_q[0];
          idx_d     = 4'd1;
          cnt_d     = '0;
          state_d   = S_SEND;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_SEND, S_ACK, S_WAIT_IDLE: begin
        // The transfer watchdog wins over an edge arriving in the same cycle.
        if (cnt_q == XFER_LAST) begin
          data_oe_d = 1'b0;
          status_d  = 2'b11;
          state_d   = S_FINISH;
        end else begin
          cnt_d = cnt_q + 32'd1;
          if (state_q == S_SEND && clk_fall) begin
            data_oe_d = ~frame_q[idx_q];
            idx_d     = idx_q + 4'd1;
            if (idx_q == 4'd9) state_d = S_ACK;
          end else if (state_q == S_ACK && clk_fall) begin
            status_d = {1'b0, data_s2_q};
            state_d  = S_WAIT_IDLE;
          end else if (state_q == S_WAIT_IDLE && clk_s2_q && data_s2_q) begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = ~tx_ready;
  assign done        = (state_q == S_FINISH);
  assign status      = status_q;
  assign ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_REQ);
  assign ps2_data_oe = data_oe_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain PS/2 device model clocks frames out of the
// host and the captured bits, status and timing are compared against expectations.
module tb_ps2_host_tx;

  localparam int INH  = 120;
  localparam int STO  = 3000;
  localparam int XTO  = 2000;
  localparam int HALF = 20;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, done;
  logic [1:0] status;
  logic       ps2_clk_oe, ps2_data_oe;
  logic [2:0] dbg_state;
  logic       dev_clk_low, dev_data_low;
  logic       clk_line, data_line;

  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .START_TIMEOUT_CYCLES(STO), .XFER_TIMEOUT_CYCLES(XTO)
  ) dut (
    .clock_100Mhz(clk), .reset(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .status(status),
    .ps2_clk_in(clk_line), .ps2_data_in(data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int oe_rise_cyc = 0;
  int inh_cnt = 0;
  int first_fall_cyc = 0;
  logic [1:0] last_status = 2'b00;
  logic clk_oe_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      last_status = status;
    end
    if (ps2_clk_oe && !clk_oe_prev) oe_rise_cyc = cyc;
    if (ps2_clk_oe && !ps2_data_oe) inh_cnt++;
    clk_oe_prev = ps2_clk_oe;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not end, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [10:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference frame as the device must see it: start, LSB-first data, odd parity, stop.
  function automatic logic [10:0] frame_model(input logic [7:0] d);
    logic [10:0] b;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[i+1] = d[i];
    b[9]  = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    b[10] = 1'b1;
    return b;
  endfunction

  // driver tasks
  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    inh_cnt  = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic bfm_run(input int nfalls, input bit ack_low,
                         output logic [10:0] bits, output bit started);
    started = 1'b0;
    bits = '0;
    for (int i = 0; i < INH + 200 && !started; i++) begin
      @(negedge clk);
      if (clk_line && !data_line) started = 1'b1;
    end
    if (!started) return;
    repeat (10) @(posedge clk);
    bits[0] = data_line;
    for (int i = 1; i <= nfalls && i <= 10; i++) begin
      @(posedge clk);
      #1 dev_clk_low = 1'b1;
      if (i == 1) first_fall_cyc = cyc;
      repeat (HALF) @(posedge clk);
      #1 dev_clk_low = 1'b0;
      bits[i] = data_line;
      repeat (HALF) @(posedge clk);
    end
    if (nfalls >= 11) begin
      #1 dev_data_low = ack_low;
      repeat (5) @(posedge clk);
      #1 dev_clk_low = 1'b1;
      repeat (HALF) @(posedge clk);
      #1 dev_clk_low = 1'b0;
      repeat (3) @(posedge clk);
      #1 dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_done(input int c0, input int bound, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (done_cnt != c0) seen = 1'b1;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic do_xfer(input logic [7:0] d, input bit ack_low,
                         input logic [1:0] exp_status, input string tag);
    logic [10:0] bits;
    bit started;
    int c0;
    c0 = done_cnt;
    exp_q.push_back(frame_model(d));
    send_byte(d);
    bfm_run(11, ack_low, bits, started);
    chk({tag, "_start_seen"}, {31'd0, started}, 32'd1);
    chk({tag, "_frame_bits"}, {21'd0, bits}, {21'd0, exp_q.pop_front()});
    chk({tag, "_inhibit_cycles"}, inh_cnt, INH);
    wait_done(c0, XTO, {tag, "_done_seen"});
    chk({tag, "_status"}, {30'd0, last_status}, {30'd0, exp_status});
    repeat (3) @(negedge clk);
    chk({tag, "_done_once"}, done_cnt - c0, 32'd1);
    chk({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack_low;
    logic [1:0] exp_status;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [10:0] bits;
    bit started;
    int c0;
    int diff;

    tbl[0] = '{8'hF4, 1'b1, 2'b00};
    tbl[1] = '{8'hFF, 1'b0, 2'b01};
    for (int i = 2; i < 6; i++) begin
      tbl[i].data       = 8'($urandom_range(0, 255));
      tbl[i].ack_low    = 1'($urandom_range(0, 1));
      tbl[i].exp_status = tbl[i].ack_low ? 2'b00 : 2'b01;
    end

    rst_n = 1'b0;
    tx_data = 8'h00;
    tx_valid = 1'b0;
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_status", {30'd0, status}, 32'd0);
    chk("reset_oes", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk("reset_state", {29'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) do_xfer(tbl[i].data, tbl[i].ack_low, tbl[i].exp_status, "vec");

    // start timeout: device never clocks
    c0 = done_cnt;
    send_byte(8'h00);
    wait_done(c0, INH + STO + 200, "sto_done_seen");
    diff = done_cyc - oe_rise_cyc;
    chk("sto_latency_window",
        {31'd0, (diff >= INH + 1 + STO - 3) && (diff <= INH + 1 + STO + 3)}, 32'd1);
    chk("sto_status", {30'd0, last_status}, 32'd2);
    chk("sto_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);

    // transfer timeout: device stops after four bits
    c0 = done_cnt;
    send_byte(8'hA5);
    bfm_run(4, 1'b1, bits, started);
    chk("xto_start_seen", {31'd0, started}, 32'd1);
    wait_done(c0, XTO + 200, "xto_done_seen");
    diff = done_cyc - first_fall_cyc;
    chk("xto_latency_window", {31'd0, (diff >= XTO - 1) && (diff <= XTO + 7)}, 32'd1);
    chk("xto_status", {30'd0, last_status}, 32'd3);
    @(negedge clk);
    chk("xto_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);

    // asynchronous reset during bit 5
    c0 = done_cnt;
    send_byte(8'h00);
    bfm_run(5, 1'b1, bits, started);
    @(posedge clk);
    #2;
    chk("rst_data_oe_before", {31'd0, ps2_data_oe}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_oes_async_drop", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_no_done", done_cnt - c0, 32'd0);

    // tx_valid held across a transfer
    c0 = done_cnt;
    @(negedge clk);
    inh_cnt = 0;
    tx_data = 8'hF4;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_data = 8'h11;
    exp_q.push_back(frame_model(8'hF4));
    bfm_run(11, 1'b1, bits, started);
    chk("hold_frame_bits", {21'd0, bits}, {21'd0, exp_q.pop_front()});
    begin
      bit ready_seen = 1'b0;
      for (int i = 0; i < XTO && !ready_seen; i++) begin
        @(negedge clk);
        if (tx_ready) ready_seen = 1'b1;
      end
      chk("hold_ready_return", {31'd0, ready_seen}, 32'd1);
    end
    chk("hold_done_once", done_cnt - c0, 32'd1);
    chk("hold_status", {30'd0, last_status}, 32'd0);
    @(negedge clk);
    chk("hold_accept_next_cycle", {31'd0, tx_ready}, 32'd0);
    tx_valid = 1'b0;
    c0 = done_cnt;
    inh_cnt = 0;
    exp_q.push_back(frame_model(8'h11));
    bfm_run(11, 1'b1, bits, started);
    chk("hold_second_bits", {21'd0, bits}, {21'd0, exp_q.pop_front()});
    wait_done(c0, XTO, "hold_second_done");
    chk("hold_second_status", {30'd0, last_status}, 32'd0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
